// File: rtl/bf_ctrl_pkg.sv
// bf_ctrl_pkg: shared FSM state encodings and command codes for the TinyBF execution controller
package bf_ctrl_pkg;
    localparam int CMD_W = 2;
    localparam logic [CMD_W-1:0] CMD_LOAD = 2'b00;
    localparam logic [CMD_W-1:0] CMD_RUN  = 2'b01;
    localparam logic [CMD_W-1:0] CMD_HALT = 2'b10;
    localparam logic [CMD_W-1:0] CMD_STEP = 2'b11;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    // single-cycle step out of PAUSE, reachable only when stepping is built in
    localparam logic [2:0] S_STEP  = 3'd6;
endpackage

// File: rtl/bf_ctrl_loader.sv
// bf_ctrl_loader: program loader - write pointer, ready, RAM write port, last/overflow detection
//  clr_i     clear write pointer (entering LOAD)
//  active_i  controller is in LOAD; drives ld_ready
//  ld_*      valid/ready instruction stream
//  wr_*      RAM write port (wr_en_o = accepted beat)
//  last_o    accepted beat carried ld_last
//  ovf_o     accepted final slot without ld_last
//  len_o     program length including this cycle's beat
module bf_ctrl_loader #(
    parameter int PROG_AW = 5,
    parameter int INSTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               active_i,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               wr_en_o,
    output logic [PROG_AW-1:0] wr_addr_o,
    output logic [INSTR_W-1:0] wr_data_o,
    output logic               last_o,
    output logic               ovf_o,
    output logic [PROG_AW:0]   len_o
);
    localparam logic [PROG_AW:0] ONE = (PROG_AW+1)'(1);
    logic [PROG_AW:0] wptr_q, wptr_d;
    assign ld_ready  = active_i;
    assign wr_en_o   = active_i & ld_valid;
    assign wr_addr_o = wptr_q[PROG_AW-1:0];
    assign wr_data_o = ld_data;
    assign last_o    = wr_en_o & ld_last;
    // the FSM leaves LOAD on overflow, so the pointer never passes the last slot while active
    assign ovf_o     = wr_en_o & ~ld_last & (&wptr_q[PROG_AW-1:0]);
    assign len_o     = wr_en_o ? wptr_q + ONE : wptr_q;
    assign wptr_d    = clr_i ? '0 : len_o;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wptr_q <= '0;
        else     wptr_q <= wptr_d;
    end
endmodule

// File: rtl/bf_exec_ctrl.sv
// bf_exec_ctrl: TinyBF execution controller - program load, run/pause/stop FSM, RAM port mux, cycle counter
//  cmd_valid/cmd      command strobe (LOAD, RUN, HALT, STEP)
//  ld_*               program load stream into RAM
//  cpu_mem_*          core fetch request/grant
//  mem_*              shared single-port program RAM
//  cpu_rst/cpu_run    core reset and clock enable; cpu_halted from core
//  prog_len/cyc_cnt   stored program length, saturating run-cycle count
//  state/done/err     FSM state, RUN->DONE pulse, rejected-command/overflow pulse
//  Define BF_CTRL_STEP_EN to enable single-stepping out of PAUSE.
module bf_exec_ctrl
    import bf_ctrl_pkg::*;
#(
    parameter int PROG_AW = 5,
    parameter int INSTR_W = 3,
    parameter int CYC_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [CMD_W-1:0]   cmd,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    input  logic               cpu_mem_req,
    input  logic [PROG_AW-1:0] cpu_mem_addr,
    output logic               cpu_mem_gnt,
    output logic               mem_en,
    output logic               mem_we,
    output logic [PROG_AW-1:0] mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_rst,
    output logic               cpu_run,
    input  logic               cpu_halted,
    output logic [PROG_AW:0]   prog_len,
    output logic [CYC_W-1:0]   cyc_cnt,
    output logic [2:0]         state,
    output logic               done,
    output logic               err
);
    logic [2:0]         state_q, state_d;
    logic [PROG_AW:0]   prog_len_q, prog_len_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               done_q, done_d, err_q, err_d, ld_clr;
    logic               wr_en, ld_hit_last, ld_ovf, is_ld;
    logic [PROG_AW-1:0] wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [PROG_AW:0]   ld_len;
    logic               c_load, c_run, c_halt, c_step;
    assign c_load = cmd_valid & (cmd == CMD_LOAD);
    assign c_run  = cmd_valid & (cmd == CMD_RUN);
    assign c_halt = cmd_valid & (cmd == CMD_HALT);
    assign c_step = cmd_valid & (cmd == CMD_STEP);
    assign is_ld  = state_q == S_LOAD;
    bf_ctrl_loader #(.PROG_AW(PROG_AW), .INSTR_W(INSTR_W)) u_loader (
        .clk(clk), .rst(rst), .clr_i(ld_clr), .active_i(is_ld),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .last_o(ld_hit_last), .ovf_o(ld_ovf), .len_o(ld_len)
    );
    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ld_clr     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (c_load) begin
                    state_d    = S_LOAD;
                    prog_len_d = '0;
                    ld_clr     = 1'b1;
                end else if (c_run) begin
                    if (prog_len_q != '0) state_d = S_START;
                    else                  err_d   = 1'b1;
                end else if (c_halt && state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                err_d = err_d | c_step;
            end
            S_LOAD: begin
                // a beat accepted alongside HALT still counts toward the stored length
                if (ld_hit_last || ld_ovf || c_halt) begin
                    state_d    = S_IDLE;
                    prog_len_d = ld_len;
                end
                err_d = ld_ovf | c_run | c_step;
            end
            S_START: begin
                state_d = S_RUN;
                err_d   = c_step;
            end
            S_RUN: begin
                if (cpu_halted) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (c_halt) begin
                    state_d = S_PAUSE;
                end
                err_d = c_load | c_step;
            end
            S_PAUSE: begin
                if (c_run)       state_d = S_RUN;
                else if (c_halt) state_d = S_IDLE;
`ifdef BF_CTRL_STEP_EN
                else if (c_step) state_d = S_STEP;
                err_d = c_load;
`else
                err_d = c_load | c_step;
`endif
            end
`ifdef BF_CTRL_STEP_EN
            S_STEP: begin
                state_d = cpu_halted ? S_DONE : S_PAUSE;
                done_d  = cpu_halted;
                err_d   = c_load | c_step;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end
    assign cpu_run     = (state_q == S_RUN) | (state_q == S_STEP);
    assign cpu_rst     = (state_q == S_IDLE) | is_ld | (state_q == S_START);
    assign cpu_mem_gnt = cpu_run & cpu_mem_req;
    assign mem_en      = is_ld ? wr_en : cpu_mem_gnt;
    assign mem_we      = is_ld & wr_en;
    assign mem_addr    = is_ld ? wr_addr : (cpu_mem_gnt ? cpu_mem_addr : '0);
    assign mem_wdata   = mem_we ? wr_data : '0;
    assign cyc_d       = (state_q == S_START) ? '0 :
                         (cpu_run && !(&cyc_q)) ? cyc_q + CYC_W'(1) : cyc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prog_len_q <= '0;
            cyc_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            cyc_q      <= cyc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
    assign state    = state_q;
    assign prog_len = prog_len_q;
    assign cyc_cnt  = cyc_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_bf_exec_ctrl.sv
// tb_bf_exec_ctrl: randomized self-checking bench for bf_exec_ctrl against a behavioural model
module tb_bf_exec_ctrl;
    import bf_ctrl_pkg::*;
    localparam int AW = 5;
    localparam int IW = 3;
    localparam int CW = 16;
    localparam int SLOTS = 1 << AW;
    localparam int CYC_MAX = (1 << CW) - 1;
    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd = '0;
    logic          ld_valid = 1'b0, ld_ready, ld_last = 1'b0;
    logic [IW-1:0] ld_data = '0;
    logic          cpu_mem_req = 1'b0, cpu_mem_gnt;
    logic [AW-1:0] cpu_mem_addr = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          cpu_rst, cpu_run, cpu_halted = 1'b0;
    logic [AW:0]   prog_len;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    state;
    logic          done, err;
    int            n_chk = 0, n_fail = 0;
    logic [IW-1:0] ram  [SLOTS];
    logic [IW-1:0] prog [SLOTS];
    int            exp_cyc;

    bf_exec_ctrl #(.PROG_AW(AW), .INSTR_W(IW), .CYC_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .cpu_mem_req(cpu_mem_req), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_gnt(cpu_mem_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .prog_len(prog_len), .cyc_cnt(cyc_cnt), .state(state), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // program RAM model: whatever the controller writes lands here
    always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        tick();
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic load_prog(input int n, input bit with_last);
        int i;
        i = 0;
        send(CMD_LOAD);
        chk("load_state", 32'(state), 32'(S_LOAD));
        chk("load_len_clr", 32'(prog_len), 0);
        while (i < n) begin
            if ($urandom_range(3) == 0) begin
                ld_valid = 1'b0;
                #1;
                chk("gap_mem_en", 32'(mem_en), 0);
                tick();
            end else begin
                prog[i] = IW'($urandom);
                ld_valid = 1'b1;
                ld_data = prog[i];
                ld_last = with_last && (i == n - 1);
                #1;
                chk("ld_ready", 32'(ld_ready), 1);
                chk("wr_we", 32'(mem_we), 1);
                chk("wr_addr", 32'(mem_addr), 32'(i));
                chk("wr_data", 32'(mem_wdata), 32'(prog[i]));
                tick();
                i++;
            end
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        #1;
        chk("load_end_state", 32'(state), 32'(S_IDLE));
        chk("load_len", 32'(prog_len), 32'(n));
        chk("load_err", 32'(err), with_last ? 0 : 1);
        for (int j = 0; j < n; j++) chk("ram_word", 32'(ram[j]), 32'(prog[j]));
    endtask

    task automatic run_prog(input int k);
        logic          req;
        logic [AW-1:0] addr;
        send(CMD_RUN);
        chk("start_state", 32'(state), 32'(S_START));
        chk("start_rst", 32'(cpu_rst), 1);
        chk("start_run", 32'(cpu_run), 0);
        tick();
        chk("run_state", 32'(state), 32'(S_RUN));
        chk("run_cyc0", 32'(cyc_cnt), 0);
        for (int j = 1; j <= k; j++) begin
            req = 1'($urandom);
            addr = AW'($urandom);
            cpu_mem_req = req;
            cpu_mem_addr = addr;
            cpu_halted = (j == k);
            #1;
            if (j <= 4 || j == k) begin
                chk("run_cpu_run", 32'(cpu_run), 1);
                chk("run_cpu_rst", 32'(cpu_rst), 0);
                chk("fetch_gnt", 32'(cpu_mem_gnt), 32'(req));
                chk("fetch_en", 32'(mem_en), 32'(req));
                chk("fetch_we", 32'(mem_we), 0);
                chk("fetch_addr", 32'(mem_addr), req ? 32'(addr) : 0);
            end
            tick();
        end
        cpu_halted = 1'b0;
        cpu_mem_req = 1'b0;
        #1;
        chk("done_state", 32'(state), 32'(S_DONE));
        chk("done_pulse", 32'(done), 1);
        chk("done_cyc", 32'(cyc_cnt), 32'(k > CYC_MAX ? CYC_MAX : k));
        tick();
        chk("done_clear", 32'(done), 0);
        chk("done_run_off", 32'(cpu_run), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_cyc", 32'(cyc_cnt), 0);
        chk("rst_len", 32'(prog_len), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_done_err", 32'({done, err, cpu_run}), 0);
        rst = 1'b0;
        tick();
        // RUN with empty program is rejected
        send(CMD_RUN);
        chk("run_empty_err", 32'(err), 1);
        chk("run_empty_state", 32'(state), 32'(S_IDLE));
        tick();
        chk("err_clear", 32'(err), 0);
        // five-beat program
        load_prog(5, 1'b1);
        // RUN inside LOAD is rejected, HALT aborts with nothing stored
        send(CMD_LOAD);
        send(CMD_RUN);
        chk("load_run_err", 32'(err), 1);
        chk("load_run_state", 32'(state), 32'(S_LOAD));
        send(CMD_HALT);
        chk("abort_state", 32'(state), 32'(S_IDLE));
        chk("abort_len", 32'(prog_len), 0);
        // full memory without ld_last overflows, next beat stalls
        load_prog(SLOTS, 1'b0);
        ld_valid = 1'b1;
        #1;
        chk("stall_ready", 32'(ld_ready), 0);
        chk("stall_mem_en", 32'(mem_en), 0);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("ovf_err_pulse", 32'(err), 0);
        chk("ovf_len_hold", 32'(prog_len), 32'(SLOTS));
        // randomized load/run rounds
        for (int r = 0; r < 4; r++) begin
            load_prog(int'($urandom_range(1, SLOTS)), 1'b1);
            run_prog(int'($urandom_range(1, 20)));
            send(CMD_HALT);
            chk("done_halt_idle", 32'(state), 32'(S_IDLE));
        end
        run_prog(10);
        // pause / step / resume, then HALT and cpu_halted together
        send(CMD_RUN);
        tick();
        exp_cyc = 0;
        send(CMD_LOAD);
        exp_cyc++;
        chk("run_load_err", 32'(err), 1);
        chk("run_load_state", 32'(state), 32'(S_RUN));
        repeat ($urandom_range(1, 6)) begin
            tick();
            exp_cyc++;
        end
        send(CMD_HALT);
        exp_cyc++;
        chk("pause_state", 32'(state), 32'(S_PAUSE));
        chk("pause_cyc", 32'(cyc_cnt), 32'(exp_cyc));
        cpu_mem_req = 1'b1;
        #1;
        chk("pause_run", 32'(cpu_run), 0);
        chk("pause_rst", 32'(cpu_rst), 0);
        chk("pause_gnt", 32'(cpu_mem_gnt), 0);
        send(CMD_STEP);
`ifdef BF_CTRL_STEP_EN
        chk("step_run", 32'(cpu_run), 1);
        chk("step_gnt", 32'(cpu_mem_gnt), 1);
        tick();
        exp_cyc++;
        chk("step_back", 32'(state), 32'(S_PAUSE));
        chk("step_run_off", 32'(cpu_run), 0);
`else
        chk("step_err", 32'(err), 1);
        chk("step_state", 32'(state), 32'(S_PAUSE));
        chk("step_run", 32'(cpu_run), 0);
        tick();
`endif
        chk("step_cyc", 32'(cyc_cnt), 32'(exp_cyc));
        cpu_mem_req = 1'b0;
        send(CMD_RUN);
        chk("resume_state", 32'(state), 32'(S_RUN));
        chk("resume_cyc", 32'(cyc_cnt), 32'(exp_cyc));
        cpu_halted = 1'b1;
        send(CMD_HALT);
        cpu_halted = 1'b0;
        exp_cyc++;
        chk("halt_win_state", 32'(state), 32'(S_DONE));
        chk("halt_win_done", 32'(done), 1);
        chk("halt_win_cyc", 32'(cyc_cnt), 32'(exp_cyc));
        // asynchronous reset mid-run
        send(CMD_RUN);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_len", 32'(prog_len), 0);
        chk("arst_cpu", 32'({cpu_rst, cpu_run}), 2);
        tick();
        rst = 1'b0;
        tick();
        // saturating cycle counter
        load_prog(3, 1'b1);
        run_prog(CYC_MAX + 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
